// File: rtl/gvp_stream_pkg.sv
// Shared constants and types for the GVP stream packer: packet type codes,
// metadata lengths and the framing FSM states.
package gvp_stream_pkg;

   localparam logic [3:0] TYPE_DATA = 4'h1;
   localparam logic [3:0] TYPE_VEC  = 4'h2;
   localparam logic [3:0] TYPE_END  = 4'hF;

   localparam int META_LEN_DATA = 1;
   localparam int META_LEN_VEC  = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_META = 2'd2,
      S_CHAN = 2'd3
   } state_t;

   // Map the core's store_data code onto the header type nibble.
   function automatic logic [3:0] type_code(input logic [1:0] sd);
      logic [3:0] t;
      case (sd)
         2'd1:    t = TYPE_DATA;
         2'd2:    t = TYPE_VEC;
         2'd3:    t = TYPE_END;
         default: t = 4'h0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/gvp_mask_scan.sv
// Combinational scan of a channel mask: index of the lowest set bit and the
// number of set bits.
module gvp_mask_scan #(
   parameter int N  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1,
   parameter int PW = $clog2(N + 1)
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] low_idx,
   output logic [PW-1:0] pop_cnt
);

   // Descending walk so the lowest set bit is the last one to win.
   always_comb begin
      low_idx = '0;
      pop_cnt = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) low_idx = IW'(i);
         pop_cnt = pop_cnt + PW'(mask[i]);
      end
   end

endmodule

// File: rtl/gvp_stream_packer.sv
// Snapshots GVP core outputs on each store trigger and emits them as one
// framed packet on a 32-bit AXI-Stream master, stalling the core meanwhile.
//
// state  | meaning
// IDLE   | waiting for a store trigger; tvalid low
// HDR    | header word presented
// META   | index / time / vector words, counter mcnt_q
// CHAN   | selected channels, lowest remaining mask bit first
module gvp_stream_packer
   import gvp_stream_pkg::*;
#(
   parameter int N_CH     = 16,
   parameter int SRCS_LSB = 16
) (
   input  logic                a_clk,
   input  logic                a_resetn,
   input  logic [1:0]          store_data,
   input  logic                store_tick,
   input  logic [31:0]         gvp_index,
   input  logic [47:0]         gvp_time,
   input  logic [31:0]         gvp_x,
   input  logic [31:0]         gvp_y,
   input  logic [31:0]         gvp_z,
   input  logic [31:0]         gvp_u,
   input  logic [31:0]         gvp_srcs,
   input  logic [N_CH*32-1:0]  ch_data,
   output logic [31:0]         M_AXIS_tdata,
   output logic                M_AXIS_tvalid,
   input  logic                M_AXIS_tready,
   output logic                M_AXIS_tlast,
   output logic                stall,
   output logic                overflow,
   output logic [15:0]         drop_count
);

   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW = $clog2(N_CH + 1);

   state_t            state_q, state_d;
   logic [3:0]        type_q, type_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic [2:0]        mcnt_q, mcnt_d;
   logic [31:0]       index_q, index_d;
   logic [47:0]       time_q, time_d;
   logic [31:0]       x_q, x_d, y_q, y_d, z_q, z_d, u_q, u_d;
   logic [31:0]       ch_q [N_CH];
   logic [31:0]       ch_d [N_CH];
   logic              stall_q, stall_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_q, drop_d;

   logic [IW-1:0]     low_idx;
   logic [PW-1:0]     pop_cnt;
   logic              trig, hs, meta_last;
   logic [2:0]        meta_end;
   logic [7:0]        pay_cnt;
   logic              unused_srcs;

   assign unused_srcs = ^gvp_srcs;

   // One scanner on the shadow mask: its popcount sizes the header while in
   // HDR (mask still complete), its lowest index drives the walk in CHAN.
   gvp_mask_scan #(.N(N_CH), .IW(IW), .PW(PW)) u_scan (
      .mask    (mask_q),
      .low_idx (low_idx),
      .pop_cnt (pop_cnt)
   );

   assign trig      = store_tick && (store_data != 2'd0);
   assign hs        = (state_q != S_IDLE) && M_AXIS_tready;
   assign meta_end  = (type_q == TYPE_DATA) ? 3'(META_LEN_DATA - 1) : 3'(META_LEN_VEC - 1);
   assign meta_last = (mcnt_q == meta_end);
   assign pay_cnt   = 8'(pop_cnt) + ((type_q == TYPE_DATA) ? 8'(META_LEN_DATA) : 8'(META_LEN_VEC));

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      mask_d     = mask_q;
      mcnt_d     = mcnt_q;
      index_d    = index_q;
      time_d     = time_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      u_d        = u_q;
      ch_d       = ch_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d = S_HDR;
               type_d  = type_code(store_data);
               mask_d  = gvp_srcs[SRCS_LSB +: N_CH];
               mcnt_d  = 3'd0;
               index_d = gvp_index;
               time_d  = gvp_time;
               x_d     = gvp_x;
               y_d     = gvp_y;
               z_d     = gvp_z;
               u_d     = gvp_u;
               for (int k = 0; k < N_CH; k++) ch_d[k] = ch_data[32*k +: 32];
            end
         end
         S_HDR: begin
            if (hs) state_d = S_META;
         end
         S_META: begin
            if (hs) begin
               if (meta_last) state_d = (mask_q != '0) ? S_CHAN : S_IDLE;
               else           mcnt_d  = mcnt_q + 3'd1;
            end
         end
         S_CHAN: begin
            if (hs) begin
               mask_d = mask_q & (mask_q - 1'b1);
               if (pop_cnt == PW'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (trig && (state_q != S_IDLE)) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end

      stall_d = (state_d != S_IDLE);
   end

   always_ff @(posedge a_clk) begin
      if (!a_resetn) begin
         state_q    <= S_IDLE;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Shadow registers only matter outside IDLE, so they need no reset.
   always_ff @(posedge a_clk) begin
      type_q  <= type_d;
      mask_q  <= mask_d;
      mcnt_q  <= mcnt_d;
      index_q <= index_d;
      time_q  <= time_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      u_q     <= u_d;
      for (int k = 0; k < N_CH; k++) ch_q[k] <= ch_d[k];
   end

   always_comb begin
      M_AXIS_tdata = '0;
      M_AXIS_tlast = 1'b0;
      case (state_q)
         S_HDR: M_AXIS_tdata = {type_q, 4'h0, pay_cnt, 16'(mask_q)};
         S_META: begin
            case (mcnt_q)
               3'd0:    M_AXIS_tdata = index_q;
               3'd1:    M_AXIS_tdata = time_q[31:0];
               3'd2:    M_AXIS_tdata = {16'h0, time_q[47:32]};
               3'd3:    M_AXIS_tdata = x_q;
               3'd4:    M_AXIS_tdata = y_q;
               3'd5:    M_AXIS_tdata = z_q;
               default: M_AXIS_tdata = u_q;
            endcase
            M_AXIS_tlast = meta_last && (mask_q == '0);
         end
         S_CHAN: begin
            M_AXIS_tdata = ch_q[low_idx];
            M_AXIS_tlast = (pop_cnt == PW'(1));
         end
         default: ;
      endcase
   end

   assign M_AXIS_tvalid = (state_q != S_IDLE);
   assign stall         = stall_q;
   assign overflow      = overflow_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_gvp_stream_packer.sv
// Bench for gvp_stream_packer: packet vectors from a table feed a word
// scoreboard, plus hand sequences for drops, saturation and reset.
module tb_gvp_stream_packer;

   localparam int N_CH = 16;

   logic               a_clk = 1'b0;
   logic               a_resetn;
   logic [1:0]         store_data;
   logic               store_tick;
   logic [31:0]        gvp_index, gvp_x, gvp_y, gvp_z, gvp_u, gvp_srcs;
   logic [47:0]        gvp_time;
   logic [N_CH*32-1:0] ch_data;
   logic [31:0]        M_AXIS_tdata;
   logic               M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
   logic               stall, overflow;
   logic [15:0]        drop_count;

   gvp_stream_packer #(.N_CH(N_CH), .SRCS_LSB(16)) dut (
      .a_clk(a_clk), .a_resetn(a_resetn), .store_data(store_data), .store_tick(store_tick),
      .gvp_index(gvp_index), .gvp_time(gvp_time), .gvp_x(gvp_x), .gvp_y(gvp_y),
      .gvp_z(gvp_z), .gvp_u(gvp_u), .gvp_srcs(gvp_srcs), .ch_data(ch_data),
      .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
      .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tlast(M_AXIS_tlast),
      .stall(stall), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 a_clk = ~a_clk;

   typedef struct {
      logic [1:0]  sd;
      logic [15:0] mask;
      logic [31:0] idx;
      logic [47:0] tm;
      logic [31:0] x, y, z, u, chbase;
      int          mode;
      logic [31:0] exp_hdr;
      int          exp_stall;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   int     tests = 0;
   int     fails = 0;
   word_t  sb[$];
   int     tr_mode = 0;
   int     tready_cyc = 0;
   int     exp_drop = 0;
   bit     hold = 0;
   logic [31:0] hold_d;
   logic   hold_l;
   word_t  w;
   vec_t   vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] chval(input logic [31:0] base, input int k);
      return base + 32'h11 * 32'(k + 1);
   endfunction

   function automatic vec_t mk(input logic [1:0] sd, input logic [15:0] mask,
                               input logic [31:0] idx, input logic [47:0] tm,
                               input logic [31:0] x0, input logic [31:0] chbase,
                               input int mode, input logic [31:0] hdr, input int st);
      vec_t v;
      v.sd = sd; v.mask = mask; v.idx = idx; v.tm = tm;
      v.x = x0; v.y = x0 + 1; v.z = x0 + 2; v.u = x0 + 3;
      v.chbase = chbase; v.mode = mode; v.exp_hdr = hdr; v.exp_stall = st;
      return v;
   endfunction

   task automatic push(input logic [31:0] d, input logic l);
      word_t e;
      e.data = d;
      e.last = l;
      sb.push_back(e);
   endtask

   // Drives one trigger, queues the expected packet, then scrambles inputs.
   task automatic start_pkt(input vec_t v, input bit hold_tick);
      logic [31:0] pl[$];
      @(negedge a_clk);
      tr_mode    = v.mode;
      store_data = v.sd;
      store_tick = 1'b1;
      gvp_index  = v.idx;
      gvp_time   = v.tm;
      gvp_x = v.x; gvp_y = v.y; gvp_z = v.z; gvp_u = v.u;
      gvp_srcs   = {v.mask, 16'($urandom)};
      for (int k = 0; k < N_CH; k++) ch_data[32*k +: 32] = chval(v.chbase, k);
      pl.push_back(v.idx);
      if (v.sd != 2'd1) begin
         pl.push_back(v.tm[31:0]);
         pl.push_back({16'h0, v.tm[47:32]});
         pl.push_back(v.x); pl.push_back(v.y); pl.push_back(v.z); pl.push_back(v.u);
      end
      for (int k = 0; k < N_CH; k++) if (v.mask[k]) pl.push_back(chval(v.chbase, k));
      push(v.exp_hdr, 1'b0);
      for (int i = 0; i < pl.size(); i++) push(pl[i], (i == pl.size() - 1));
      @(negedge a_clk);
      if (!hold_tick) store_tick = 1'b0;
      gvp_index = $urandom;
      gvp_time  = 48'({$urandom, $urandom});
      gvp_x = $urandom; gvp_y = $urandom; gvp_z = $urandom; gvp_u = $urandom;
      gvp_srcs  = $urandom;
      for (int k = 0; k < N_CH; k++) ch_data[32*k +: 32] = $urandom;
      #1;
      chk("hdr_latency_tvalid", M_AXIS_tvalid, 1);
      chk("hdr_latency_stall", stall, 1);
   endtask

   task automatic wait_idle(input string name, output int stall_cyc);
      int n = 1;
      bit done = 0;
      for (int c = 0; c < 600 && !done; c++) begin
         @(negedge a_clk);
         #1;
         if (stall) n++;
         else       done = 1;
      end
      stall_cyc = n;
      chk({name, "_idle_reached"}, done, 1);
      chk({name, "_sb_empty"}, sb.size(), 0);
   endtask

   // tready generator
   initial begin
      M_AXIS_tready = 1'b1;
      forever begin
         @(negedge a_clk);
         tready_cyc++;
         case (tr_mode)
            0:       M_AXIS_tready = 1'b1;
            1:       M_AXIS_tready = (tready_cyc % 3 == 0);
            2:       M_AXIS_tready = 1'($urandom_range(0, 1));
            default: M_AXIS_tready = 1'b0;
         endcase
      end
   end

   // Monitor: scoreboard pops on handshake, stability check under backpressure.
   initial begin
      forever begin
         @(negedge a_clk);
         #1;
         if (!a_resetn) begin
            hold = 0;
         end else begin
            if (hold) begin
               chk("hold_tvalid", M_AXIS_tvalid, 1);
               chk("hold_tdata", M_AXIS_tdata, hold_d);
               chk("hold_tlast", M_AXIS_tlast, hold_l);
            end
            hold = 0;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_word: got 0x%08h, expected no word", M_AXIS_tdata);
               end else begin
                  w = sb.pop_front();
                  chk("word_data", M_AXIS_tdata, w.data);
                  chk("word_last", M_AXIS_tlast, w.last);
               end
            end else if (M_AXIS_tvalid) begin
               hold   = 1;
               hold_d = M_AXIS_tdata;
               hold_l = M_AXIS_tlast;
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      int base;
      logic [15:0] cur;
      vecs[0] = mk(2'd1, 16'h0005, 32'h2A, 48'h0, 32'h0, 32'h0, 0, 32'h10030005, 4);
      vecs[1] = mk(2'd2, 16'h0000, 32'h55, 48'h0001_2345_6789, 32'h1, 32'h0, 0, 32'h20070000, 8);
      vecs[2] = mk(2'd1, 16'h0005, 32'h2A, 48'h0, 32'h0, 32'h0, 1, 32'h10030005, -1);
      vecs[3] = mk(2'd3, 16'hFFFF, 32'h7, 48'hABCD_0000_1234, 32'h100, 32'h1000, 0, 32'hF017FFFF, 24);
      vecs[4] = mk(2'd2, 16'h8001, 32'h99, 48'hFFFF_FFFF_FFFF, 32'hA0, 32'h5000, 2, 32'h20098001, -1);
      vecs[5] = mk(2'd1, 16'h0000, 32'h3, 48'h0, 32'h0, 32'h0, 0, 32'h10010000, 2);
      vecs[6] = mk(2'd1, 16'h8000, 32'h4, 48'h0, 32'h0, 32'h7000, 0, 32'h10028000, 3);
      vecs[7] = mk(2'd3, 16'h0000, 32'h5, 48'h1234_5678_9ABC, 32'h10, 32'h0, 1, 32'hF0070000, -1);

      a_resetn = 1'b0; store_data = 2'd0; store_tick = 1'b0;
      gvp_index = '0; gvp_time = '0; gvp_x = '0; gvp_y = '0; gvp_z = '0; gvp_u = '0;
      gvp_srcs = '0; ch_data = '0;
      repeat (3) @(negedge a_clk);
      #1;
      chk("rst_tvalid", M_AXIS_tvalid, 0);
      chk("rst_tlast", M_AXIS_tlast, 0);
      chk("rst_tdata", M_AXIS_tdata, 0);
      chk("rst_stall", stall, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop", drop_count, 0);
      @(negedge a_clk);
      a_resetn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         start_pkt(vecs[i], 1'b0);
         wait_idle("vec", sc);
         if (vecs[i].exp_stall > 0) chk("stall_cycles", sc, vecs[i].exp_stall);
         chk("vec_overflow", overflow, 0);
         chk("vec_drop", drop_count, 0);
      end

      // store_tick with store_data=0 is not a trigger
      tr_mode = 0;
      @(negedge a_clk);
      store_data = 2'd0; store_tick = 1'b1;
      @(negedge a_clk);
      store_tick = 1'b0;
      #1;
      chk("nulltick_stall", stall, 0);
      chk("nulltick_tvalid", M_AXIS_tvalid, 0);
      wait_idle("nulltick", sc);

      // trigger coincident with the final handshake is dropped
      start_pkt(vecs[5], 1'b0);
      @(negedge a_clk);
      store_data = 2'd1; store_tick = 1'b1;
      @(negedge a_clk);
      store_tick = 1'b0;
      exp_drop++;
      #1;
      chk("b2b_stall", stall, 0);
      chk("b2b_drop", drop_count, 16'(exp_drop));
      chk("b2b_overflow", overflow, 1);
      wait_idle("b2b", sc);

      // drop while busy; null tick while busy does not count
      start_pkt(vecs[0], 1'b0);
      @(negedge a_clk);
      store_data = 2'd1; store_tick = 1'b1;
      @(negedge a_clk);
      exp_drop++;
      store_data = 2'd0;
      @(negedge a_clk);
      store_tick = 1'b0;
      #1;
      chk("drop_overflow", overflow, 1);
      chk("drop_count", drop_count, 16'(exp_drop));
      wait_idle("drop", sc);
      chk("drop_count_after", drop_count, 16'(exp_drop));

      // saturation: hold tick high while the packet is stalled
      begin
         vec_t v;
         v = vecs[0];
         v.mode = 3;
         base = exp_drop;
         start_pkt(v, 1'b1);
         for (int m = 1; m <= 65535; m++) begin
            @(negedge a_clk);
            #1;
            cur = (base + m > 65535) ? 16'hFFFF : 16'(base + m);
            if (m == 65535 || base + m == 65534 || base + m == 65535)
               chk("sat_drop", drop_count, cur);
         end
         store_tick = 1'b0;
         store_data = 2'd0;
         exp_drop = 65535;
         tr_mode = 0;
         wait_idle("sat", sc);
         chk("sat_final", drop_count, 16'hFFFF);
         chk("sat_overflow", overflow, 1);
      end

      // reset during CHAN aborts the packet
      start_pkt(vecs[3], 1'b0);
      repeat (9) @(negedge a_clk);
      #1;
      chk("prerst_overflow", overflow, 1);
      @(negedge a_clk);
      a_resetn = 1'b0;
      sb.delete();
      @(negedge a_clk);
      a_resetn = 1'b1;
      #1;
      chk("midrst_tvalid", M_AXIS_tvalid, 0);
      chk("midrst_tlast", M_AXIS_tlast, 0);
      chk("midrst_tdata", M_AXIS_tdata, 0);
      chk("midrst_stall", stall, 0);
      chk("midrst_overflow", overflow, 0);
      chk("midrst_drop", drop_count, 0);
      exp_drop = 0;
      start_pkt(vecs[0], 1'b0);
      wait_idle("postrst", sc);
      chk("postrst_stall_cycles", sc, 4);
      chk("postrst_overflow", overflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
